// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU load/store path and an external host/DMA port.
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_load_req/cpu_stor_req     CPU requests (held until cpu_done), cpu_addr/cpu_wdata
//   cpu_rdata/cpu_done/cpu_stall  CPU load data, completion pulse, pipeline freeze
//   ext_req/ext_we/ext_addr/ext_wdata, ext_rdata/ext_ack   external port request and completion
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata/mem_rdy     memory strobe side and answer
//   err_timeout/err_both          sticky error flags
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_load_req,
  input  logic          cpu_stor_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy,
  output logic          err_timeout,
  output logic          err_both
);
  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);
  state_t state;
  logic owner_ext;
  logic last_cpu;
  logic [7:0] cnt;
  logic cpu_pend;
  logic grant_cpu;
  logic [DW-1:0] result;
  assign cpu_pend = cpu_load_req | cpu_stor_req;
  // on a tie the requester that did not win the previous grant goes first
  assign grant_cpu = cpu_pend & (~ext_req | ~last_cpu);
  // a timed-out access returns zero instead of whatever is on the bus
  assign result = mem_rdy ? mem_rdata : '0;
  assign cpu_stall = cpu_pend & ~(state == DONE & ~owner_ext);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_ext   <= 1'b0;
      last_cpu    <= 1'b0;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_done    <= 1'b0;
      ext_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ext_rdata   <= '0;
      err_timeout <= 1'b0;
      err_both    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu_pend | ext_req) begin
          state     <= ACC;
          owner_ext <= ~grant_cpu;
          last_cpu  <= grant_cpu;
          mem_en    <= 1'b1;
          // a conflicting load+store from the CPU is carried out as a store
          mem_we    <= grant_cpu ? cpu_stor_req : ext_we;
          mem_addr  <= grant_cpu ? cpu_addr : ext_addr;
          mem_wdata <= grant_cpu ? cpu_wdata : ext_wdata;
          if (grant_cpu & cpu_load_req & cpu_stor_req) err_both <= 1'b1;
        end
        ACC: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= '0;
          state  <= WAIT;
        end
        WAIT: if (mem_rdy || cnt == CNT_MAX) begin
          state     <= DONE;
          cpu_done  <= ~owner_ext;
          ext_ack   <= owner_ext;
          cpu_rdata <= owner_ext ? '0 : result;
          ext_rdata <= owner_ext ? result : '0;
          if (!mem_rdy) err_timeout <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          cpu_done  <= 1'b0;
          ext_ack   <= 1'b0;
          cpu_rdata <= '0;
          ext_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random traffic on both ports against a transaction-level model of the arbiter.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int T = 15;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_load_req, cpu_stor_req, cpu_done, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic ext_req, ext_we, ext_ack;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic mem_en, mem_we, mem_rdy, err_timeout, err_both;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_load_req(cpu_load_req), .cpu_stor_req(cpu_stor_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .err_timeout(err_timeout), .err_both(err_both)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  int g = 0;
  int done_c = 0;
  int lat = 0;
  bit hold, busy, oc, tout, e_we, e_both, last_cpu, m_err_to, m_err_both;
  bit cpu_act, ext_act, cpu_pulsed, ext_pulsed;
  logic [7:0] e_addr, e_wdata, rd, res;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  task automatic start_cpu();
    int k = int'($urandom_range(0, 4));
    cpu_act = 1'b1;
    cpu_load_req = (k < 2) || (k == 4);
    cpu_stor_req = (k >= 2);
    cpu_addr = 8'($urandom);
    cpu_wdata = 8'($urandom);
  endtask
  task automatic start_ext();
    ext_act = 1'b1;
    ext_req = 1'b1;
    ext_we = 1'($urandom);
    ext_addr = 8'($urandom);
    ext_wdata = 8'($urandom);
  endtask
  task automatic cycle(input bit do_rst);
    bit p;
    @(posedge clk);
    #1;
    n++;
    if (cpu_pulsed) begin
      if (hold || $urandom_range(0, 1) == 1) start_cpu();
      else begin cpu_act = 1'b0; cpu_load_req = 1'b0; cpu_stor_req = 1'b0; end
    end else if (!cpu_act && (hold || $urandom_range(0, 2) == 0)) start_cpu();
    if (ext_pulsed) begin
      if (hold || $urandom_range(0, 1) == 1) start_ext();
      else begin ext_act = 1'b0; ext_req = 1'b0; end
    end else if (!ext_act && (hold || $urandom_range(0, 2) == 0)) start_ext();
    cpu_pulsed = 1'b0;
    ext_pulsed = 1'b0;
    if (do_rst) begin
      #1 rst_n = 1'b0;
      #1 check("async_reset_outputs", 64'({mem_en, mem_we, mem_addr, mem_wdata, cpu_done, ext_ack,
                                         cpu_rdata, ext_rdata, err_timeout, err_both}), 64'd0);
      rst_n = 1'b1;
      busy = 1'b0;
      last_cpu = 1'b0;
      m_err_to = 1'b0;
      m_err_both = 1'b0;
    end
    if (busy && n > done_c) busy = 1'b0;
    if (!busy && (cpu_load_req || cpu_stor_req || ext_req)) begin
      oc = (cpu_load_req || cpu_stor_req) && (!ext_req || !last_cpu);
      last_cpu = oc;
      e_addr = oc ? cpu_addr : ext_addr;
      e_wdata = oc ? cpu_wdata : ext_wdata;
      e_we = oc ? cpu_stor_req : ext_we;
      e_both = oc && cpu_load_req && cpu_stor_req;
      lat = ($urandom_range(0, 3) == 0) ? T + 1 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 6));
      rd = 8'($urandom);
      tout = lat > T + 1;
      res = tout ? 8'd0 : rd;
      g = n;
      done_c = n + 2 + (tout ? T + 1 : lat);
      busy = 1'b1;
    end
    if (busy && n > g + 1 && n < done_c) begin
      mem_rdy = (n == g + 1 + lat);
      mem_rdata = mem_rdy ? rd : 8'($urandom);
    end else begin
      mem_rdy = ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
    end
    @(negedge clk);
    p = busy && n == done_c;
    if (busy && n == g + 1 && e_both) m_err_both = 1'b1;
    if (p && tout) m_err_to = 1'b1;
    check("mem_en", 64'(mem_en), 64'(busy && n == g + 1));
    if (busy && n == g + 1) check("mem_access", 64'({mem_we, mem_addr, mem_wdata}), 64'({e_we, e_addr, e_wdata}));
    check("cpu_done", 64'(cpu_done), 64'(p && oc));
    check("ext_ack", 64'(ext_ack), 64'(p && !oc));
    check("cpu_rdata", 64'(cpu_rdata), 64'((p && oc) ? res : 8'd0));
    check("ext_rdata", 64'(ext_rdata), 64'((p && !oc) ? res : 8'd0));
    check("cpu_stall", 64'(cpu_stall), 64'((cpu_load_req || cpu_stor_req) && !(p && oc)));
    check("err_flags", 64'({err_timeout, err_both}), 64'({m_err_to, m_err_both}));
    cpu_pulsed = p && oc;
    ext_pulsed = p && !oc;
  endtask
  initial begin
    rst_n = 1'b0;
    cpu_load_req = 1'b0; cpu_stor_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;
    {hold, busy, oc, tout, e_we, e_both, last_cpu, m_err_to, m_err_both} = '0;
    {cpu_act, ext_act, cpu_pulsed, ext_pulsed} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({mem_en, mem_we, mem_addr, mem_wdata, cpu_done, ext_ack,
                             cpu_rdata, ext_rdata, err_timeout, err_both}), 64'd0);
    check("reset_stall", 64'(cpu_stall), 64'd0);
    rst_n = 1'b1;
    hold = 1'b1;
    repeat (150) cycle(1'b0);
    hold = 1'b0;
    repeat (3000) cycle(n > 200 && $urandom_range(0, 249) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
